// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Operation sequencer for the shared 8-bit 2A03 ALU. It accepts one
//   operation at a time over a valid/ready handshake and latches its operands.
//   It then drives the ALU with one-hot function enables, operands and
//   carry-in. The ALU result is registered, and N/Z/C/V are derived together
//   with per-flag update strobes. ADW (16-bit base + signed 8-bit offset,
//   used for branch targets) takes two ALU passes.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   op_valid/op_ready request handshake (ready only in IDLE, not in reset)
//   op_code           operation select (0..C legal, D..F illegal)
//   a_in, a_hi_in     operand A / 16-bit base {a_hi_in, a_in}
//   b_in, c_in        operand B / signed offset, incoming carry
//   alu_*_en          one-hot ALU function enables, alu_inv_en inverts B
//   alu_a, alu_b      ALU operands (from latched operands only)
//   alu_cin           ALU carry-in
//   alu_res/cout/ovf  combinational ALU results
//   res_out           result / low byte, res_hi_out high byte (ADW)
//   res_we            write-back strobe (with done)
//   flag_n/z/c/v      registered flags
//   upd_nz/c/v        flag write strobes (with done)
//   done              one-cycle completion pulse
//   err               one-cycle pulse with done for an illegal op_code
module alu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [3:0] op_code,
  input  logic [7:0] a_in,
  input  logic [7:0] a_hi_in,
  input  logic [7:0] b_in,
  input  logic       c_in,
  output logic       alu_sum_en,
  output logic       alu_and_en,
  output logic       alu_eor_en,
  output logic       alu_or_en,
  output logic       alu_sr_en,
  output logic       alu_ror_en,
  output logic       alu_inv_en,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_cin,
  input  logic [7:0] alu_res,
  input  logic       alu_cout,
  input  logic       alu_ovf,
  output logic [7:0] res_out,
  output logic [7:0] res_hi_out,
  output logic       res_we,
  output logic       flag_n,
  output logic       flag_z,
  output logic       flag_c,
  output logic       flag_v,
  output logic       upd_nz,
  output logic       upd_c,
  output logic       upd_v,
  output logic       done,
  output logic       err
);

  localparam int DATA_W = 8;

  localparam logic [3:0] OP_ADC = 4'h0;
  localparam logic [3:0] OP_SBC = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_ORA = 4'h3;
  localparam logic [3:0] OP_EOR = 4'h4;
  localparam logic [3:0] OP_ASL = 4'h5;
  localparam logic [3:0] OP_ROL = 4'h6;
  localparam logic [3:0] OP_LSR = 4'h7;
  localparam logic [3:0] OP_ROR = 4'h8;
  localparam logic [3:0] OP_CMP = 4'h9;
  localparam logic [3:0] OP_INC = 4'hA;
  localparam logic [3:0] OP_DEC = 4'hB;
  localparam logic [3:0] OP_ADW = 4'hC;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC1 = 2'd1,
    S_EXEC2 = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [3:0]               op_p0;
  logic [DATA_W-1:0]        a_p0;
  logic [DATA_W-1:0]        a_hi_p0;
  logic signed [DATA_W-1:0] b_p0;
  logic                     c_p0;
  logic                     carry_p1;

  logic dec_we, dec_nz, dec_c, dec_v, dec_ill;

  assign op_ready = (state == S_IDLE) && !rst;

  // Which results the latched operation writes back.
  always_comb begin
    dec_we  = 1'b0;
    dec_nz  = 1'b0;
    dec_c   = 1'b0;
    dec_v   = 1'b0;
    dec_ill = 1'b0;
    case (op_p0)
      OP_ADC, OP_SBC: begin
        dec_we = 1'b1; dec_nz = 1'b1; dec_c = 1'b1; dec_v = 1'b1;
      end
      OP_AND, OP_ORA, OP_EOR, OP_INC, OP_DEC: begin
        dec_we = 1'b1; dec_nz = 1'b1;
      end
      OP_ASL, OP_ROL, OP_LSR, OP_ROR: begin
        dec_we = 1'b1; dec_nz = 1'b1; dec_c = 1'b1;
      end
      OP_CMP: begin
        dec_nz = 1'b1; dec_c = 1'b1;
      end
      OP_ADW: dec_we = 1'b1;
      default: dec_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and ALU drive; the ALU is idle (all zero) outside EXEC1/EXEC2.
  always_comb begin
    state_nxt  = state;
    alu_sum_en = 1'b0;
    alu_and_en = 1'b0;
    alu_eor_en = 1'b0;
    alu_or_en  = 1'b0;
    alu_sr_en  = 1'b0;
    alu_ror_en = 1'b0;
    alu_inv_en = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_cin    = 1'b0;
    case (state)
      S_IDLE: begin
        if (op_valid && op_ready) state_nxt = S_EXEC1;
      end
      S_EXEC1: begin
        state_nxt = (op_p0 == OP_ADW) ? S_EXEC2 : S_DONE;
        alu_a     = a_p0;
        case (op_p0)
          OP_ADC: begin alu_sum_en = 1'b1; alu_b = b_p0; alu_cin = c_p0; end
          OP_SBC: begin
            alu_sum_en = 1'b1; alu_inv_en = 1'b1; alu_b = b_p0; alu_cin = c_p0;
          end
          OP_AND: begin alu_and_en = 1'b1; alu_b = b_p0; end
          OP_ORA: begin alu_or_en  = 1'b1; alu_b = b_p0; end
          OP_EOR: begin alu_eor_en = 1'b1; alu_b = b_p0; end
          // Shifts left are A + A so the ALU carry-out is A[7].
          OP_ASL: begin alu_sum_en = 1'b1; alu_b = a_p0; end
          OP_ROL: begin alu_sum_en = 1'b1; alu_b = a_p0; alu_cin = c_p0; end
          OP_LSR: alu_sr_en = 1'b1;
          OP_ROR: begin alu_ror_en = 1'b1; alu_cin = c_p0; end
          OP_CMP: begin
            alu_sum_en = 1'b1; alu_inv_en = 1'b1; alu_b = b_p0; alu_cin = 1'b1;
          end
          OP_INC: begin alu_sum_en = 1'b1; alu_b = 8'h01; end
          // A + ~1 + 1 = A - 1
          OP_DEC: begin
            alu_sum_en = 1'b1; alu_inv_en = 1'b1; alu_b = 8'h01; alu_cin = 1'b1;
          end
          OP_ADW: begin alu_sum_en = 1'b1; alu_b = b_p0; end
          default: ;
        endcase
      end
      S_EXEC2: begin
        // ADW high byte: base high + sign extension of offset + low carry.
        state_nxt  = S_DONE;
        alu_sum_en = 1'b1;
        alu_a      = a_hi_p0;
        alu_b      = {DATA_W{b_p0[DATA_W-1]}};
        alu_cin    = carry_p1;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_p0      <= '0;
      a_p0       <= '0;
      a_hi_p0    <= '0;
      b_p0       <= '0;
      c_p0       <= 1'b0;
      carry_p1   <= 1'b0;
      res_out    <= '0;
      res_hi_out <= '0;
      flag_n     <= 1'b0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      flag_v     <= 1'b0;
      res_we     <= 1'b0;
      upd_nz     <= 1'b0;
      upd_c      <= 1'b0;
      upd_v      <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      res_we <= 1'b0;
      upd_nz <= 1'b0;
      upd_c  <= 1'b0;
      upd_v  <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      case (state)
        // Stage p0: operand latch at acceptance.
        S_IDLE: begin
          if (op_valid) begin
            op_p0   <= op_code;
            a_p0    <= a_in;
            a_hi_p0 <= a_hi_in;
            b_p0    <= b_in;
            c_p0    <= c_in;
          end
        end
        // Stage p1: first-pass capture.
        S_EXEC1: begin
          if (dec_ill) begin
            done <= 1'b1;
            err  <= 1'b1;
          end else if (op_p0 == OP_ADW) begin
            res_out  <= alu_res;
            carry_p1 <= alu_cout;
          end else begin
            done   <= 1'b1;
            res_we <= dec_we;
            upd_nz <= dec_nz;
            upd_c  <= dec_c;
            upd_v  <= dec_v;
            if (dec_we) res_out <= alu_res;
            if (dec_nz) begin
              flag_n <= alu_res[DATA_W-1];
              flag_z <= (alu_res == '0);
            end
            if (dec_c) flag_c <= alu_cout;
            if (dec_v) flag_v <= alu_ovf;
          end
        end
        // Stage p2: ADW high-byte capture.
        S_EXEC2: begin
          res_hi_out <= alu_res;
          res_we     <= 1'b1;
          done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: models the external ALU from its contract, drives
// directed and random operations and compares against an arithmetic model.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid;
  logic       op_ready;
  logic [3:0] op_code;
  logic [7:0] a_in, a_hi_in, b_in;
  logic       c_in;
  logic       alu_sum_en, alu_and_en, alu_eor_en, alu_or_en;
  logic       alu_sr_en, alu_ror_en, alu_inv_en;
  logic [7:0] alu_a, alu_b;
  logic       alu_cin;
  logic [7:0] alu_res;
  logic       alu_cout, alu_ovf;
  logic [7:0] res_out, res_hi_out;
  logic       res_we;
  logic       flag_n, flag_z, flag_c, flag_v;
  logic       upd_nz, upd_c, upd_v;
  logic       done, err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_res, m_hi;
  logic       m_n, m_z, m_c, m_v;

  logic [6:0] en_vec;
  logic [7:0] bm;
  logic [8:0] s9;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .a_in(a_in), .a_hi_in(a_hi_in), .b_in(b_in), .c_in(c_in),
    .alu_sum_en(alu_sum_en), .alu_and_en(alu_and_en), .alu_eor_en(alu_eor_en),
    .alu_or_en(alu_or_en), .alu_sr_en(alu_sr_en), .alu_ror_en(alu_ror_en),
    .alu_inv_en(alu_inv_en), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_res(alu_res), .alu_cout(alu_cout), .alu_ovf(alu_ovf),
    .res_out(res_out), .res_hi_out(res_hi_out), .res_we(res_we),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .upd_nz(upd_nz), .upd_c(upd_c), .upd_v(upd_v), .done(done), .err(err)
  );

  assign en_vec = {alu_sum_en, alu_and_en, alu_eor_en, alu_or_en,
                   alu_sr_en, alu_ror_en, alu_inv_en};

  // External ALU, behaving per its contract.
  always_comb begin
    bm       = alu_inv_en ? ~alu_b : alu_b;
    s9       = {1'b0, alu_a} + {1'b0, bm} + {8'b0, alu_cin};
    alu_res  = 8'h00;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    if (alu_sum_en) begin
      alu_res  = s9[7:0];
      alu_cout = s9[8];
      alu_ovf  = (alu_a[7] == bm[7]) && (s9[7] != alu_a[7]);
    end else if (alu_and_en) alu_res = alu_a & alu_b;
    else if (alu_or_en)      alu_res = alu_a | alu_b;
    else if (alu_eor_en)     alu_res = alu_a ^ alu_b;
    else if (alu_sr_en) begin
      alu_res = {1'b0, alu_a[7:1]}; alu_cout = alu_a[0];
    end else if (alu_ror_en) begin
      alu_res = {alu_cin, alu_a[7:1]}; alu_cout = alu_a[0];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: instruction semantics with plain integer arithmetic.
  task automatic ref_op(input logic [3:0] op, input logic [7:0] a, ah, b, input logic c,
                        output logic [7:0] r, output logic [7:0] hi,
                        output logic fc, output logic fv,
                        output logic we, output logic unz, output logic uc,
                        output logic uv, output logic er);
    int ai, bi, ci, sa, sb, s, sv, tgt;
    ai = a; bi = b; ci = c; sa = $signed(a); sb = $signed(b);
    s = 0; sv = 0; tgt = 0;
    hi = m_hi; fc = 1'b0; fv = 1'b0;
    we = 1'b0; unz = 1'b0; uc = 1'b0; uv = 1'b0; er = 1'b0;
    case (op)
      4'h0: begin
        s = ai + bi + ci; sv = sa + sb + ci;
        fc = (s > 255); fv = (sv > 127) || (sv < -128);
        we = 1; unz = 1; uc = 1; uv = 1;
      end
      4'h1: begin
        s = ai - bi - (1 - ci); sv = sa - sb - (1 - ci);
        fc = (s >= 0); fv = (sv > 127) || (sv < -128);
        we = 1; unz = 1; uc = 1; uv = 1;
      end
      4'h2: begin s = ai & bi; we = 1; unz = 1; end
      4'h3: begin s = ai | bi; we = 1; unz = 1; end
      4'h4: begin s = ai ^ bi; we = 1; unz = 1; end
      4'h5: begin s = ai * 2;      fc = (ai >= 128); we = 1; unz = 1; uc = 1; end
      4'h6: begin s = ai * 2 + ci; fc = (ai >= 128); we = 1; unz = 1; uc = 1; end
      4'h7: begin s = ai / 2;      fc = (ai % 2 == 1); we = 1; unz = 1; uc = 1; end
      4'h8: begin s = ai / 2 + ci * 128; fc = (ai % 2 == 1); we = 1; unz = 1; uc = 1; end
      4'h9: begin s = ai - bi; fc = (ai >= bi); unz = 1; uc = 1; end
      4'hA: begin s = ai + 1; we = 1; unz = 1; end
      4'hB: begin s = ai - 1; we = 1; unz = 1; end
      4'hC: begin
        tgt = int'(ah) * 256 + ai + sb;
        s = tgt;
        hi = tgt[15:8];
        we = 1;
      end
      default: er = 1;
    endcase
    r = s[7:0];
  endtask

  task automatic run_op(input logic [3:0] op, input logic [7:0] a, ah, b,
                        input logic c, input string tag);
    logic [7:0] r, hi;
    logic fc, fv, we, unz, uc, uv, er;
    int lat;
    int exp_lat;
    ref_op(op, a, ah, b, c, r, hi, fc, fv, we, unz, uc, uv, er);
    if (we) m_res = r;
    if (op == 4'hC) m_hi = hi;
    if (unz) begin m_n = r[7]; m_z = (r == 8'h00); end
    if (uc) m_c = fc;
    if (uv) m_v = fv;
    exp_lat = (op == 4'hC) ? 3 : 2;

    op_valid = 1'b1; op_code = op; a_in = a; a_hi_in = ah; b_in = b; c_in = c;
    chk({tag, "_ready"}, 16'(op_ready), 16'd1);
    tick();
    op_valid = 1'b0;
    op_code  = 4'($urandom_range(0, 15));
    a_in     = 8'($urandom);
    a_hi_in  = 8'($urandom);
    b_in     = 8'($urandom);
    c_in     = 1'($urandom);
    lat = 1;
    while (done !== 1'b1 && lat < 8) begin
      chk({tag, "_busy"}, 16'(op_ready), 16'd0);
      chk({tag, "_onehot"}, 16'($countones(en_vec[6:1]) <= 1), 16'd1);
      if (er) chk({tag, "_noen"}, 16'(en_vec), 16'd0);
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 16'(lat), 16'(exp_lat));
    chk({tag, "_done"}, 16'(done), 16'd1);
    chk({tag, "_strobes"}, 16'({res_we, upd_nz, upd_c, upd_v, err}),
        16'({we, unz, uc, uv, er}));
    chk({tag, "_res"}, 16'(res_out), 16'(m_res));
    chk({tag, "_hi"}, 16'(res_hi_out), 16'(m_hi));
    chk({tag, "_flags"}, 16'({flag_n, flag_z, flag_c, flag_v}), 16'({m_n, m_z, m_c, m_v}));
    chk({tag, "_idle_en"}, 16'({en_vec, alu_cin}), 16'd0);
    tick();
    chk({tag, "_pulse"}, 16'({done, res_we, upd_nz, upd_c, upd_v, err}), 16'd0);
    chk({tag, "_ready2"}, 16'(op_ready), 16'd1);
  endtask

  task automatic model_reset();
    m_res = 8'h00; m_hi = 8'h00;
    m_n = 1'b0; m_z = 1'b0; m_c = 1'b0; m_v = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 16'({op_ready, en_vec, alu_cin, res_we, flag_n, flag_z, flag_c,
                            flag_v, upd_nz, upd_c, upd_v, done, err}), 16'd0);
    chk({tag, "_ops"}, {alu_a, alu_b}, 16'd0);
    chk({tag, "_res"}, {res_hi_out, res_out}, 16'd0);
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_code = 4'h0;
    a_in = 8'h00; a_hi_in = 8'h00; b_in = 8'h00; c_in = 1'b0;
    model_reset();
    tick();
    tick();
    chk_zero("reset");
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 16'(op_ready), 16'd1);

    // Directed cases
    run_op(4'h0, 8'h7F, 8'h00, 8'h7F, 1'b1, "adc");
    run_op(4'h1, 8'h00, 8'h00, 8'h01, 1'b1, "sbc");
    run_op(4'h9, 8'h40, 8'h00, 8'h40, 1'b0, "cmp");
    run_op(4'h5, 8'h81, 8'h00, 8'h00, 1'b0, "asl");
    run_op(4'h8, 8'h01, 8'h00, 8'h00, 1'b1, "ror");
    run_op(4'hA, 8'hFF, 8'h00, 8'h00, 1'b0, "inc");
    run_op(4'hC, 8'hF0, 8'h12, 8'h20, 1'b0, "adw_fwd");
    run_op(4'hC, 8'h00, 8'h12, 8'h80, 1'b1, "adw_back");
    run_op(4'hE, 8'h55, 8'h66, 8'h77, 1'b1, "illegal");
    run_op(4'hB, 8'h00, 8'h00, 8'h00, 1'b0, "dec");

    // Random operations
    for (int i = 0; i < 60; i++) begin
      run_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 8'($urandom),
             1'($urandom), $sformatf("rnd%0d", i));
    end

    // Reset while ADW is in its second pass, with op_valid held throughout
    op_valid = 1'b1; op_code = 4'hC; a_in = 8'hF0; a_hi_in = 8'h12; b_in = 8'h20; c_in = 1'b0;
    tick();
    tick();
    chk("rst_mid_exec2_busy", 16'({op_ready, done}), 16'd0);
    rst = 1'b1;
    op_code = 4'h0; a_in = 8'h01; b_in = 8'h02; c_in = 1'b0;
    tick();
    chk_zero("rst_mid");
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_ready", 16'(op_ready), 16'd1);
    run_op(4'h0, 8'h01, 8'h00, 8'h02, 1'b0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Operation sequencer for the 8-bit 2A03 ALU. It accepts one ALU operation at a time over a valid/ready handshake and drives the ALU's one-hot function enables, operands and carry-in. It registers RES/Cout/OVFout and derives N/Z/C/V with per-flag update strobes. It also sequences the two-pass 16-bit signed-offset add used for branch targets, and sits between CPU control decode and the shared ALU.

## Interface
- No parameters; all data paths 8-bit.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- op_valid  in  1  request present
- op_ready  out  1  sequencer can accept (IDLE and not in reset)
- op_code  in  4  operation select (see Operation)
- a_in  in  8  operand A / low byte of 16-bit base
- a_hi_in  in  8  high byte of 16-bit base (ADW only)
- b_in  in  8  operand B / signed offset (ADW)
- c_in  in  1  incoming carry flag
- alu_sum_en, alu_and_en, alu_eor_en, alu_or_en, alu_sr_en, alu_ror_en  out  1 each  one-hot ALU function enables
- alu_inv_en  out  1  invert B before sum
- alu_a, alu_b  out  8  ALU operands
- alu_cin  out  1  ALU carry-in
- alu_res  in  8; alu_cout  in  1; alu_ovf  in  1  ALU results (combinational)
- res_out  out  8  result / low byte
- res_hi_out  out  8  high byte (ADW)
- res_we  out  1  result should be written back (valid with done)
- flag_n, flag_z, flag_c, flag_v  out  1  computed flags
- upd_nz, upd_c, upd_v  out  1  flag write strobes (valid with done)
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done for illegal op_code

## Operation
- ALU contract: exactly one function enable at a time; SUM = A + (inv ? ~B : B) + Cin; SR = {0, A[7:1]}, ROR = {Cin, A[7:1]}, Cout = A[0] for both.
- Op map (enable, alu_b, alu_cin; writes res/flags):
  - 0 ADC: SUM, b_in, c_in; res, NZ, C, V
  - 1 SBC: SUM+INV, b_in, c_in; res, NZ, C, V
  - 2 AND / 3 ORA / 4 EOR: matching enable, b_in; res, NZ
  - 5 ASL: SUM, a_in, 0; res, NZ, C
  - 6 ROL: SUM, a_in, c_in; res, NZ, C
  - 7 LSR: SR, Cin 0; res, NZ, C
  - 8 ROR: ROR, Cin c_in; res, NZ, C
  - 9 CMP: SUM+INV, b_in, 1; NZ, C only, res_we=0
  - A INC: SUM, 0x01, 0; res, NZ
  - B DEC: SUM+INV, 0x01, 1; res, NZ
  - C ADW: pass1 SUM a_in+b_in, Cin 0 -> res_out; pass2 SUM a_hi_in + {8{b_in[7]}} + pass1 Cout -> res_hi_out; res_we=1, no flag updates
  - D-F: illegal; no enable asserted, err=1, res_we=0, no flag updates, outputs hold
- Flags: N = res[7], Z = (res==0), C = alu_cout, V = alu_ovf, captured from the pass that produced res.
- FSM: IDLE -> EXEC1 on op_valid&op_ready (latch op_code, a_in, a_hi_in, b_in, c_in). EXEC1 -> EXEC2 (ADW) else DONE. EXEC2 -> DONE. DONE -> IDLE.
- Enables, alu_inv_en and alu_cin are 0 outside EXEC1/EXEC2. alu_a/alu_b are driven from latched operands only, never from live inputs.

## Timing
- Reset: state IDLE; every output 0 (op_ready 0 while rst high, 1 the cycle after release); latched operands 0.
- Accept at edge t. EXEC1 occupies cycle t+1, with ALU result captured at edge t+2. done is high in cycle t+2 (ADW: EXEC2 in t+2, done in t+3).
- res_out/res_hi_out/flag_* hold until the next capture. res_we/upd_*/err are high only in the done cycle.
- op_ready is low from acceptance through DONE. Max throughput is one op per 3 cycles (ADW 4). op_valid held high is accepted again only in the cycle after done.
- rst asserted in any state overrides everything at that edge: return to IDLE, no done, zero outputs.
- Input changes after acceptance have no effect on the op in flight.

## Test plan
- ADC a=0x7F b=0x7F c=1 -> res_out 0xFF, N1 Z0 C0 V1, upd_nz/c/v=1, res_we=1, done 2 cycles after accept.
- SBC a=0x00 b=0x01 c=1 -> res 0xFF, N1 Z0 C0 V0. CMP a=0x40 b=0x40 -> Z1 C1 N0, res_we=0, upd_v=0.
- ASL a=0x81 -> res 0x02, C1. ROR a=0x01 c=1 -> res 0x80, C1, N1. INC 0xFF -> 0x00 Z1, upd_c=0.
- ADW {0x12,0xF0}+0x20 -> {0x13,0x10}; {0x12,0x00}+0x80 -> {0x11,0x80}; done 3 cycles after accept, all upd_*=0.
- op_code 0xE -> err=1 with done at +2, no alu_*_en ever high, prior res/flags unchanged.
- rst pulsed in ADW EXEC2 -> next cycle IDLE, all outputs 0, no done. op_valid held through -> op_ready=1 after reset release, next op accepted and completes normally.
